led_bar_driver: RTL



---
 rtl/led_bar_driver_if.sv | 28 ++
 rtl/led_bar_driver.sv | 116 +++++++++++
 2 files changed

// File: rtl/led_bar_driver_if.sv
// Bus bundle for led_bar_driver: level request strobe in, bar/status outputs back.
// The master modport is the producer of level updates; the slave is the driver.
interface led_bar_driver_if;
  logic [5:0] level;
  logic       level_valid;
  logic [7:0] led;
  logic [5:0] disp_level;
  logic       frame_tick;
  logic       settled;

  modport master (
    output level,
    output level_valid,
    input  led,
    input  disp_level,
    input  frame_tick,
    input  settled
  );

  modport slave (
    input  level,
    input  level_valid,
    output led,
    output disp_level,
    output frame_tick,
    output settled
  );
endinterface

// File: rtl/led_bar_driver.sv
// 8-LED PWM bar graph with frame-synchronous, slew-limited level updates.
// Define LED_BAR_ACTIVE_LOW_EN to invert led for current-sinking wiring (reset value 8'hFF).
module led_bar_driver #(
  parameter int unsigned PRESCALE    = 1024,
  parameter int unsigned SLEW_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  led_bar_driver_if.slave  bus
);

  localparam int unsigned PrescW    = $clog2(PRESCALE);
  localparam logic [PrescW-1:0] PrescLast = PrescW'(PRESCALE - 1);
  localparam int unsigned SlewLastI = (SLEW_FRAMES == 0) ? 0 : SLEW_FRAMES - 1;
  localparam int unsigned SlewW     = (SlewLastI > 0) ? $clog2(SlewLastI + 1) : 1;
  localparam logic [SlewW-1:0] SlewLast = SlewW'(SlewLastI);

`ifdef LED_BAR_ACTIVE_LOW_EN
  localparam logic [7:0] LedPolarity = 8'hFF;
`else
  localparam logic [7:0] LedPolarity = 8'h00;
`endif

  logic [5:0]        target_q, target_d;
  logic [5:0]        disp_q, disp_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [2:0]        slot_q, slot_d;
  logic [SlewW-1:0]  slew_q, slew_d;
  logic [7:0]        led_q, led_d;
  logic              frame_tick_q, frame_tick_d;

  logic              presc_wrap;
  logic              frame_end;
  logic [2:0]        full;
  logic [2:0]        frac;
  logic [7:0]        bar_map;

  // Timebase and capture.
  always_comb begin
    target_d = target_q;
    if (bus.level_valid) begin
      target_d = bus.level;
    end

    presc_wrap = (presc_q == PrescLast);
    frame_end  = presc_wrap && (slot_q == 3'd7);

    presc_d = presc_wrap ? '0 : presc_q + 1'b1;
    slot_d  = presc_wrap ? slot_q + 3'd1 : slot_q;

    frame_tick_d = frame_end;
  end

  // Displayed level only moves on a frame boundary; direction is recomputed every step.
  always_comb begin
    disp_d = disp_q;
    slew_d = slew_q;
    if (frame_end) begin
      if (SLEW_FRAMES == 0) begin
        disp_d = target_q;
      end else if (slew_q == SlewLast) begin
        slew_d = '0;
        if (disp_q < target_q) begin
          disp_d = disp_q + 6'd1;
        end else if (disp_q > target_q) begin
          disp_d = disp_q - 6'd1;
        end
      end else begin
        slew_d = slew_q + 1'b1;
      end
    end
  end

  // Bar map: solid below the partial LED, PWM on it, dark above it.
  always_comb begin
    full    = disp_q[5:3];
    frac    = disp_q[2:0];
    bar_map = 8'h00;
    for (int unsigned i = 0; i < 8; i++) begin
      if (3'(i) < full) begin
        bar_map[i] = 1'b1;
      end else if (3'(i) == full) begin
        bar_map[i] = (slot_q < frac);
      end else begin
        bar_map[i] = 1'b0;
      end
    end
    led_d = bar_map ^ LedPolarity;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q     <= 6'd0;
      disp_q       <= 6'd0;
      presc_q      <= '0;
      slot_q       <= 3'd0;
      slew_q       <= '0;
      led_q        <= LedPolarity;
      frame_tick_q <= 1'b0;
    end else begin
      target_q     <= target_d;
      disp_q       <= disp_d;
      presc_q      <= presc_d;
      slot_q       <= slot_d;
      slew_q       <= slew_d;
      led_q        <= led_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.led        = led_q;
  assign bus.disp_level = disp_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.settled    = (disp_q == target_q);

endmodule
